// File: rtl/lcd_pkg.sv
// Shared FSM encoding and command bytes for the LCD text sequencer.
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    ADDR1,
    LINE1,
    ADDR2,
    LINE2,
    DONE
  } lcd_state_e;

  localparam logic [7:0] CMD_CLEAR  = 8'h01;
  localparam logic [7:0] CMD_LINE1  = 8'h80;
  localparam logic [7:0] CMD_LINE2  = 8'hC0;
  localparam logic [7:0] CHAR_BLANK = 8'h20;

  function automatic logic is_char_state(input lcd_state_e s);
    return (s == LINE1) || (s == LINE2);
  endfunction

endpackage

// File: rtl/lcd_text_ram.sv
// 2*COLS x 8 character frame buffer: one write port, one combinational read port,
// synchronous active-low reset fills every entry with BLANK.
module lcd_text_ram
  import lcd_pkg::*;
#(
  parameter int         COLS  = 16,
  parameter logic [7:0] BLANK = CHAR_BLANK,
  localparam int        DEPTH = 2 * COLS,
  localparam int        AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [7:0]    wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [7:0]    rd_data_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= BLANK;
      end
    end else if (wr_en_i && (int'(wr_addr_i) < DEPTH)) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/lcd_text_sequencer.sv
// Streams an optional clear, the two line-address commands and the 2xCOLS frame
// buffer to the LCD write engine over a valid/ready byte handshake.
module lcd_text_sequencer
  import lcd_pkg::*;
#(
  parameter int         COLS        = 16,
  parameter logic [7:0] LINE1_CMD   = CMD_LINE1,
  parameter logic [7:0] LINE2_CMD   = CMD_LINE2,
  parameter bit         CLEAR_FIRST = 1'b0,
  parameter logic [7:0] BLANK       = CHAR_BLANK
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_char,
  input  logic       refresh,
  output logic       busy,
  output logic       done,
  output logic       out_valid,
  output logic [7:0] out_byte,
  output logic       out_rs,
  input  logic       out_ready
);

  localparam int            DEPTH       = 2 * COLS;
  localparam int            AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int            IW          = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [IW-1:0] LAST_IDX    = IW'(COLS - 1);
  localparam lcd_state_e    START_STATE = CLEAR_FIRST ? CLR : ADDR1;

  lcd_state_e    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          pending_q, pending_d;
  logic          out_valid_q, out_valid_d;
  logic [7:0]    out_byte_q, out_byte_d;
  logic          out_rs_q, out_rs_d;
  logic          xfer, wr_ok, load;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;

  assign wr_ok = wr_en && (int'(wr_addr) < DEPTH);
  assign xfer  = out_valid_q && out_ready;

  lcd_text_ram #(
    .COLS (COLS),
    .BLANK(BLANK)
  ) u_ram (
    .clk_i    (clk),
    .rst_ni   (reset),
    .wr_en_i  (wr_ok),
    .wr_addr_i(wr_addr[AW-1:0]),
    .wr_data_i(wr_char),
    .rd_addr_i(rd_addr),
    .rd_data_o(rd_data)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      pending_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_byte_q  <= 8'h00;
      out_rs_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      // Presented byte only changes when the sequence position moves, so it holds through stalls.
      if (load) begin
        out_valid_q <= out_valid_d;
        out_byte_q  <= out_byte_d;
        out_rs_q    <= out_rs_d;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    if (refresh && (state_q != IDLE)) pending_d = 1'b1;
    case (state_q)
      IDLE:  if (refresh) state_d = START_STATE;
      CLR:   if (xfer) state_d = ADDR1;
      ADDR1: if (xfer) begin
        state_d = LINE1;
        idx_d   = '0;
      end
      LINE1: if (xfer) begin
        if (idx_q == LAST_IDX) begin
          state_d = ADDR2;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      ADDR2: if (xfer) begin
        state_d = LINE2;
        idx_d   = '0;
      end
      LINE2: if (xfer) begin
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      // A refresh arriving in this cycle is already covered by the restart.
      DONE: begin
        pending_d = 1'b0;
        state_d   = (pending_q || refresh) ? START_STATE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load        = (state_d != state_q) || (idx_d != idx_q);
    rd_addr     = (state_d == LINE2) ? AW'(COLS + int'(idx_d)) : AW'(idx_d);
    out_valid_d = (state_d != IDLE) && (state_d != DONE);
    out_rs_d    = is_char_state(state_d);
    out_byte_d  = 8'h00;
    case (state_d)
      CLR:   out_byte_d = CMD_CLEAR;
      ADDR1: out_byte_d = LINE1_CMD;
      ADDR2: out_byte_d = LINE2_CMD;
      // Forward a same-edge write so a not-yet-sent character goes out with its new value.
      LINE1, LINE2:
        out_byte_d = (wr_ok && (int'(wr_addr) == int'(rd_addr))) ? wr_char : rd_data;
      default: out_byte_d = 8'h00;
    endcase
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    out_valid = out_valid_q;
    out_byte  = out_byte_q;
    out_rs    = out_rs_q;
  end

endmodule

// File: tb/tb_lcd_text_sequencer.sv
// Randomised bench for lcd_text_sequencer: three instances (default, clear-first, 12 columns)
// checked against a byte-list model of the refresh sequence.
module tb_lcd_text_sequencer;

  logic       clk = 1'b0;
  logic       reset, wr_en, out_ready;
  logic [4:0] wr_addr;
  logic [7:0] wr_char;
  logic [2:0] refresh_v;
  logic [2:0] busy_w, done_w, valid_w, rs_w;
  logic [7:0] byte_w [3];

  always #5 clk = ~clk;

  lcd_text_sequencer u_dut0 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char),
    .refresh(refresh_v[0]), .busy(busy_w[0]), .done(done_w[0]), .out_valid(valid_w[0]),
    .out_byte(byte_w[0]), .out_rs(rs_w[0]), .out_ready(out_ready)
  );

  lcd_text_sequencer #(.CLEAR_FIRST(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char),
    .refresh(refresh_v[1]), .busy(busy_w[1]), .done(done_w[1]), .out_valid(valid_w[1]),
    .out_byte(byte_w[1]), .out_rs(rs_w[1]), .out_ready(out_ready)
  );

  lcd_text_sequencer #(.COLS(12)) u_dut2 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char),
    .refresh(refresh_v[2]), .busy(busy_w[2]), .done(done_w[2]), .out_valid(valid_w[2]),
    .out_byte(byte_w[2]), .out_rs(rs_w[2]), .out_ready(out_ready)
  );

  int         sel;
  int         cols_of [3] = '{16, 16, 12};
  bit         cf_of   [3] = '{1'b0, 1'b1, 1'b0};
  logic [7:0] mbuf [32];
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  int         done_cyc[$];
  int         stall_viol, busy_low;
  bit         timeout_hit;
  logic       busy_after, post_valid, post_busy, post_done;
  int         n_tests = 0;
  int         n_fail  = 0;

  function automatic int seq_pos(input int k);
    int c = cols_of[sel];
    return (cf_of[sel] ? 1 : 0) + ((k < c) ? 1 + k : 2 + k);
  endfunction

  function automatic logic [8:0] got_at(input int i);
    return (i < got_q.size()) ? got_q[i] : 9'h1FF;
  endfunction

  // Expected byte list of one refresh, built from the current model buffer.
  task automatic append_expected();
    int c = cols_of[sel];
    if (cf_of[sel]) exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'h80});
    for (int k = 0; k < c; k++) exp_q.push_back({1'b1, mbuf[k]});
    exp_q.push_back({1'b0, 8'hC0});
    for (int k = 0; k < c; k++) exp_q.push_back({1'b1, mbuf[c + k]});
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_char = '0; refresh_v = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
  endtask

  task automatic write_char(input logic [4:0] a, input logic [7:0] ch);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_char = ch;
    @(negedge clk);
    wr_en = 1'b0;
    if (int'(a) < 2 * cols_of[sel]) mbuf[a] = ch;
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++)
      write_char(5'($urandom_range(0, 2 * cols_of[sel] - 1)), 8'($urandom_range(33, 126)));
  endtask

  // Issues one refresh and records every handshake; mode 0 ready=1, 1 ready 1-0-0-1, 2 random.
  task automatic stream(input int mode, input bit twice, input bit wr_rand,
                        input int abort_at, input int max_cycles);
    int ndone_exp = twice ? 2 : 1;
    int nxf = 0;
    int c = cols_of[sel];
    bit stall = 1'b0, finished = 1'b0, aborted = 1'b0;
    logic [7:0] pb = '0;
    logic prs = 1'b0;
    got_q.delete(); exp_q.delete(); done_cyc.delete();
    stall_viol = 0; busy_low = 0; timeout_hit = 1'b1;
    append_expected();
    @(negedge clk);
    refresh_v[sel] = 1'b1;
    for (int cyc = 1; cyc <= max_cycles; cyc++) begin
      @(negedge clk);
      refresh_v = '0; wr_en = 1'b0; reset = 1'b1;
      if (finished) begin
        busy_after = busy_w[sel]; timeout_hit = 1'b0;
        break;
      end
      if (aborted) begin
        post_valid = valid_w[sel]; post_busy = busy_w[sel]; post_done = done_w[sel];
        timeout_hit = 1'b0;
        break;
      end
      if (!busy_w[sel]) busy_low++;
      if (done_w[sel]) begin
        done_cyc.push_back(cyc);
        if (done_cyc.size() == 1 && twice) append_expected();
        if (done_cyc.size() == ndone_exp) finished = 1'b1;
      end
      if (stall && (valid_w[sel] !== 1'b1 || byte_w[sel] !== pb || rs_w[sel] !== prs))
        stall_viol++;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (((cyc - 1) % 4) == 0) || (((cyc - 1) % 4) == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      stall = valid_w[sel] && !out_ready;
      pb = byte_w[sel]; prs = rs_w[sel];
      if (twice && (cyc == 3 || cyc == 11 || cyc == 20)) refresh_v[sel] = 1'b1;
      if (wr_rand && $urandom_range(0, 2) == 0) begin
        int a = int'($urandom_range(0, 31));
        logic [7:0] ch = 8'($urandom_range(33, 126));
        wr_en = 1'b1; wr_addr = 5'(a); wr_char = ch;
        if (a < 2 * c) begin
          int p = seq_pos(a);
          mbuf[a] = ch;
          if (p < exp_q.size() && (p > nxf || (!valid_w[sel] && p >= nxf))) exp_q[p] = {1'b1, ch};
        end
      end
      if (valid_w[sel] && out_ready) begin
        got_q.push_back({rs_w[sel], byte_w[sel]});
        nxf++;
        if (abort_at > 0 && nxf == abort_at) begin
          reset = 1'b0; aborted = 1'b1;
        end
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      n_tests++;
      if ({busy_w[s], done_w[s], valid_w[s], rs_w[s]} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_ctrl dut%0d: busy/done/valid/rs=%b%b%b%b, expected 0000",
                 s, busy_w[s], done_w[s], valid_w[s], rs_w[s]);
      end
      n_tests++;
      if (byte_w[s] !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_byte dut%0d: got %h, expected 00", s, byte_w[s]);
      end
    end
  endtask

  task automatic test_blank_refresh();
    sel = 0;
    do_reset();
    stream(0, 1'b0, 1'b0, 0, 200);
    n_tests++;
    if (timeout_hit) begin n_fail++; $display("FAIL blank_timeout: no done within 200 cycles"); end
    n_tests++;
    if (got_q.size() != 34) begin
      n_fail++; $display("FAIL blank_count: got %0d transfers, expected 34", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL blank_byte[%0d]: got %h, expected %h", i, got_q[i], exp_q[i]);
      end
    end
    n_tests++;
    if (got_at(0) !== 9'h080 || got_at(17) !== 9'h0C0 || got_at(5) !== 9'h120) begin
      n_fail++;
      $display("FAIL blank_cmds: got %h/%h/%h, expected 080/0C0/120", got_at(0), got_at(17), got_at(5));
    end
    n_tests++;
    if (done_cyc.size() != 1 || done_cyc[0] != 35) begin
      n_fail++;
      $display("FAIL blank_done: %0d pulses, first at %0d, expected 1 at 35",
               done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1);
    end
    n_tests++;
    if (busy_low != 0 || busy_after !== 1'b0) begin
      n_fail++; $display("FAIL blank_busy: low cycles %0d, after %b, expected 0 and 0", busy_low, busy_after);
    end
  endtask

  task automatic test_chars();
    sel = 0;
    do_reset();
    write_char(5'd0, 8'h48);
    write_char(5'd1, 8'h49);
    write_char(5'd31, 8'h5A);
    for (int i = 0; i < 6; i++) write_char(5'($urandom_range(2, 30)), 8'($urandom_range(33, 126)));
    stream(0, 1'b0, 1'b0, 0, 200);
    n_tests++;
    if (got_at(1) !== 9'h148 || got_at(2) !== 9'h149 || got_at(33) !== 9'h15A) begin
      n_fail++;
      $display("FAIL chars_fixed: got %h/%h/%h, expected 148/149/15A", got_at(1), got_at(2), got_at(33));
    end
    n_tests++;
    if (got_q.size() != exp_q.size() || timeout_hit) begin
      n_fail++; $display("FAIL chars_count: got %0d, expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL chars_byte[%0d]: got %h, expected %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_stall();
    sel = 0;
    do_reset();
    fill_random(12);
    stream(1, 1'b0, 1'b0, 0, 400);
    n_tests++;
    if (stall_viol != 0) begin
      n_fail++; $display("FAIL stall_hold: %0d unstable stall cycles, expected 0", stall_viol);
    end
    n_tests++;
    if (got_q.size() != 34 || done_cyc.size() != 1 || timeout_hit) begin
      n_fail++;
      $display("FAIL stall_count: got %0d transfers %0d dones, expected 34 and 1", got_q.size(), done_cyc.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL stall_byte[%0d]: got %h, expected %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random_writes();
    sel = 0;
    do_reset();
    fill_random(8);
    stream(2, 1'b0, 1'b1, 0, 600);
    n_tests++;
    if (got_q.size() != 34 || stall_viol != 0 || timeout_hit) begin
      n_fail++;
      $display("FAIL rndwr_count: got %0d transfers %0d stall errors, expected 34 and 0", got_q.size(), stall_viol);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL rndwr_byte[%0d]: got %h, expected %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_pending();
    sel = 0;
    do_reset();
    fill_random(5);
    stream(0, 1'b1, 1'b0, 0, 300);
    n_tests++;
    if (got_q.size() != 68 || timeout_hit) begin
      n_fail++; $display("FAIL pend_count: got %0d transfers, expected 68", got_q.size());
    end
    n_tests++;
    if (done_cyc.size() != 2 || done_cyc[1] != 70) begin
      n_fail++;
      $display("FAIL pend_done: %0d pulses, second at %0d, expected 2 with second at 70",
               done_cyc.size(), (done_cyc.size() > 1) ? done_cyc[1] : -1);
    end
    n_tests++;
    if (busy_low != 0 || busy_after !== 1'b0) begin
      n_fail++; $display("FAIL pend_busy: low cycles %0d, after %b, expected 0 and 0", busy_low, busy_after);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL pend_byte[%0d]: got %h, expected %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_abort();
    sel = 0;
    do_reset();
    fill_random(10);
    stream(0, 1'b0, 1'b0, 10, 200);
    n_tests++;
    if (got_q.size() != 10 || timeout_hit) begin
      n_fail++; $display("FAIL abort_count: got %0d transfers before reset, expected 10", got_q.size());
    end
    n_tests++;
    if ({post_valid, post_busy, post_done} !== 3'b000) begin
      n_fail++;
      $display("FAIL abort_post: valid/busy/done=%b%b%b, expected 000", post_valid, post_busy, post_done);
    end
    for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
    stream(0, 1'b0, 1'b0, 0, 200);
    n_tests++;
    if (got_q.size() != 34 || got_at(0) !== 9'h080) begin
      n_fail++; $display("FAIL abort_restart: %0d transfers first %h, expected 34 and 080", got_q.size(), got_at(0));
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL abort_byte[%0d]: got %h, expected %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_clear_first();
    sel = 1;
    do_reset();
    fill_random(10);
    stream(2, 1'b0, 1'b0, 0, 600);
    n_tests++;
    if (got_q.size() != 35 || got_at(0) !== 9'h001 || got_at(1) !== 9'h080 || timeout_hit) begin
      n_fail++;
      $display("FAIL clr_head: %0d transfers first %h/%h, expected 35 and 001/080", got_q.size(), got_at(0), got_at(1));
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL clr_byte[%0d]: got %h, expected %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_addr_ignore();
    sel = 2;
    do_reset();
    write_char(5'd24, 8'h58);
    write_char(5'd27, 8'h58);
    write_char(5'd31, 8'h58);
    fill_random(6);
    stream(0, 1'b0, 1'b0, 0, 200);
    n_tests++;
    if (got_q.size() != 26 || done_cyc.size() != 1 || done_cyc[0] != 27) begin
      n_fail++;
      $display("FAIL ign_count: %0d transfers done at %0d, expected 26 and 27",
               got_q.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL ign_byte[%0d]: got %h, expected %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    sel = 0;
    reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_char = '0; refresh_v = '0; out_ready = 1'b0;
    test_reset();
    test_blank_refresh();
    test_chars();
    test_stall();
    test_random_writes();
    test_pending();
    test_abort();
    test_clear_first();
    test_addr_ignore();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
